btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 137 +++++++++++++
 rtl/btn_conditioner.sv | 45 ++++
 tb/tb_btn_conditioner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared constants and types for the button conditioner.
//   NUM_BTN              number of button channels handled by btn_conditioner
//   DEBOUNCE_CYCLES_DEF  default stable-cycle count before a level is accepted
//   REPEAT_DELAY_DEF     default hold cycles from press pulse to first repeat
//   REPEAT_PERIOD_DEF    default cycles between later repeat pulses
//   hold_phase_t         auto-repeat phase (waiting for first repeat / periodic)
//   cnt_width()          counter width: $clog2 of the largest count plus one
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int NUM_BTN             = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int REPEAT_DELAY_DEF    = 50_000_000;
    localparam int REPEAT_PERIOD_DEF   = 10_000_000;

    typedef enum logic {
        HOLD_DELAY  = 1'b0,
        HOLD_PERIOD = 1'b1
    } hold_phase_t;

    // One width shared by the debounce and hold counters so a single
    // parameter set sizes everything.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button channel: 2-flop synchronizer, mismatch-counter debounce,
// registered press/release pulses and optional auto-repeat.
// Auto-repeat is compiled in only when the macro BTN_REPEAT_EN is defined.
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   btn        raw asynchronous button, active-high
//   btn_pedge  one-cycle pulse on debounced press (and on each repeat)
//   btn_nedge  one-cycle pulse on debounced release
//   btn_level  debounced button level
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic btn_pedge,
    output logic btn_nedge,
    output logic btn_level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] db_cnt_reg;
    logic [CNT_W-1:0] db_cnt_next;
    logic             level_reg;
    logic             pedge_reg;
    logic             pedge_next;
    logic             nedge_reg;

    logic mismatch;
    logic db_done;
    logic rise;
    logic fall;
    logic repeat_fire;

    // The counter holds the number of consecutive mismatching samples seen
    // so far; the DEBOUNCE_CYCLES-th mismatching sample flips the level.
    assign mismatch = sync2_reg ^ level_reg;
    assign db_done  = mismatch && (db_cnt_reg == DB_LAST);
    assign rise     = db_done && !level_reg;
    assign fall     = db_done && level_reg;

    always_comb begin
        db_cnt_next = db_cnt_reg;
        if (!mismatch || db_done) begin
            db_cnt_next = '0;
        end else begin
            db_cnt_next = db_cnt_reg + CNT_ONE;
        end
    end

    always_comb begin
        pedge_next = rise || repeat_fire;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
            pedge_reg  <= 1'b0;
            nedge_reg  <= 1'b0;
        end else begin
            sync1_reg  <= btn;
            sync2_reg  <= sync1_reg;
            db_cnt_reg <= db_cnt_next;
            if (db_done) begin
                level_reg <= ~level_reg;
            end
            pedge_reg  <= pedge_next;
            nedge_reg  <= fall;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] hold_cnt_reg;
    logic [CNT_W-1:0] hold_cnt_next;
    hold_phase_t      phase_reg;
    hold_phase_t      phase_next;
    logic [CNT_W-1:0] hold_target;
    logic             hold_hit;

    // The hold counter starts from 0 on the press edge, so a hit on the
    // value N-1 lands the repeat pulse exactly N cycles after the previous
    // pulse. A release edge wins over a coincident repeat so pedge and nedge
    // never assert together.
    assign hold_target = (phase_reg == HOLD_DELAY) ? RD_LAST : RP_LAST;
    assign hold_hit    = (hold_cnt_reg == hold_target);
    assign repeat_fire = level_reg && !fall && hold_hit;

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        phase_next    = phase_reg;
        if (!level_reg || fall) begin
            hold_cnt_next = '0;
            phase_next    = HOLD_DELAY;
        end else if (hold_hit) begin
            hold_cnt_next = '0;
            phase_next    = HOLD_PERIOD;
        end else begin
            hold_cnt_next = hold_cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt_reg <= '0;
            phase_reg    <= HOLD_DELAY;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            phase_reg    <= phase_next;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign btn_pedge = pedge_reg;
    assign btn_nedge = nedge_reg;
    assign btn_level = level_reg;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Debounces NUM_BTN raw buttons and produces per-channel press/release
// pulses plus the debounced level. Define BTN_REPEAT_EN to add auto-repeat
// press pulses while a button is held.
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   btn        raw asynchronous buttons, active-high
//   btn_pedge  one-cycle press pulses (feeds the stopwatch btn_pedge input)
//   btn_nedge  one-cycle release pulses
//   btn_level  debounced button levels
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_pedge,
    output logic [NUM_BTN-1:0] btn_nedge,
    output logic [NUM_BTN-1:0] btn_level
);

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_chan (
                .clk       (clk),
                .reset_n   (reset_n),
                .btn       (btn[gi]),
                .btn_pedge (btn_pedge[gi]),
                .btn_nedge (btn_nedge[gi]),
                .btn_level (btn_level[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8 and a 10 ns clock. Per-cycle vector table for the simple
// press/release/glitch/bounce cases, hand sequences for repeat and reset.
// Expected repeat behaviour follows the BTN_REPEAT_EN macro.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    logic       clk;
    logic       reset_n;
    logic [2:0] btn;
    logic [2:0] btn_pedge;
    logic [2:0] btn_nedge;
    logic [2:0] btn_level;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (btn),
        .btn_pedge (btn_pedge),
        .btn_nedge (btn_nedge),
        .btn_level (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [2:0] btn;
        logic [2:0] pedge;
        logic [2:0] nedge;
        logic [2:0] level;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] b, input logic [2:0] p,
                       input logic [2:0] n, input logic [2:0] l, input int cnt);
        vec_t v;
        v.btn = b; v.pedge = p; v.nedge = n; v.level = l;
        for (int i = 0; i < cnt; i++) vecs.push_back(v);
    endtask

    // One clock step; outputs are examined 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {btn_pedge, btn_nedge, btn_level};
    endfunction

    initial begin
        int         found;
        logic [2:0] exp_p;
        logic [2:0] exp_n;
        logic [2:0] exp_l;

        // --- single press on btn[0], then release
        add(3'b001, 3'b000, 3'b000, 3'b000, 5);
        add(3'b001, 3'b001, 3'b000, 3'b001, 1);
        add(3'b001, 3'b000, 3'b000, 3'b001, 4);
        add(3'b000, 3'b000, 3'b000, 3'b001, 5);
        add(3'b000, 3'b000, 3'b001, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 4);
        // --- 2-cycle glitch on btn[1]
        add(3'b010, 3'b000, 3'b000, 3'b000, 2);
        add(3'b000, 3'b000, 3'b000, 3'b000, 8);
        // --- all three together
        add(3'b111, 3'b000, 3'b000, 3'b000, 5);
        add(3'b111, 3'b111, 3'b000, 3'b111, 1);
        add(3'b111, 3'b000, 3'b000, 3'b111, 4);
        add(3'b000, 3'b000, 3'b000, 3'b111, 5);
        add(3'b000, 3'b000, 3'b111, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 4);
        // --- bounce 1-0-1-0-1 then stable on btn[0]
        add(3'b001, 3'b000, 3'b000, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(3'b001, 3'b000, 3'b000, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(3'b001, 3'b000, 3'b000, 3'b000, 5);
        add(3'b001, 3'b001, 3'b000, 3'b001, 1);
        add(3'b001, 3'b000, 3'b000, 3'b001, 3);
        add(3'b000, 3'b000, 3'b000, 3'b001, 5);
        add(3'b000, 3'b000, 3'b001, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 2);
        // --- press btn[0], then swap to btn[1]: pedge and nedge on
        //     different channels in the same cycle
        add(3'b001, 3'b000, 3'b000, 3'b000, 5);
        add(3'b001, 3'b001, 3'b000, 3'b001, 1);
        add(3'b001, 3'b000, 3'b000, 3'b001, 4);
        add(3'b010, 3'b000, 3'b000, 3'b001, 5);
        add(3'b010, 3'b010, 3'b001, 3'b010, 1);
        add(3'b010, 3'b000, 3'b000, 3'b010, 4);
        add(3'b000, 3'b000, 3'b000, 3'b010, 5);
        add(3'b000, 3'b000, 3'b010, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 2);

        // --- reset state
        reset_n = 1'b0;
        btn     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_state%0d", i), outs(), 9'b0);
        end
        $display("reset: outs=%b", outs());
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // --- table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            btn = vecs[i].btn;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].pedge, vecs[i].nedge, vecs[i].level});
            $display("vec %0d: btn=%b pedge=%b nedge=%b level=%b",
                     i, vecs[i].btn, btn_pedge, btn_nedge, btn_level);
        end

        // --- hold btn[2]: auto-repeat when enabled, single pulse otherwise
        btn   = 3'b100;
        found = -1;
        for (int k = 0; k < 10 && found < 0; k++) begin
            tick();
            if (btn_pedge[2]) found = k;
        end
        checks++;
        if (found != 5) begin
            errors++;
            $display("FAIL rep_press_latency: got %0d required 5", found);
        end
        for (int off = 1; off <= 70; off++) begin
            if (off == 51) btn = 3'b000;
            tick();
            exp_p = 3'b000;
`ifdef BTN_REPEAT_EN
            if (off == 20 || off == 28 || off == 36 || off == 44 || off == 52)
                exp_p = 3'b100;
`endif
            exp_n = (off == 56) ? 3'b100 : 3'b000;
            exp_l = (off < 56)  ? 3'b100 : 3'b000;
            check($sformatf("repeat_off%0d", off), outs(), {exp_p, exp_n, exp_l});
        end
        $display("repeat: press at tick %0d, hold/release window done", found);

        // --- reset for one cycle mid-hold on btn[0]
        btn = 3'b001;
        for (int k = 0; k < 6; k++) tick();
        check("rst_hold_press", {6'b0, btn_pedge}, {6'b0, 3'b001});
        for (int k = 0; k < 8; k++) tick();
        reset_n = 1'b0;
        tick();
        check("rst_hold_during", outs(), 9'b0);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_p = (k == 6) ? 3'b001 : 3'b000;
            exp_l = (k >= 6) ? 3'b001 : 3'b000;
            check($sformatf("rst_hold_after%0d", k), outs(), {exp_p, 3'b000, exp_l});
        end
        $display("reset mid-hold: level=%b after re-press", btn_level);
        btn = 3'b000;
        for (int k = 0; k < 10; k++) tick();
        check("rst_hold_released", outs(), 9'b0);

        // --- reset mid-debounce aborts a press that would otherwise register
        btn = 3'b010;
        for (int k = 0; k < 3; k++) tick();
        btn     = 3'b000;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("abort_after%0d", k), outs(), 9'b0);
        end
        $display("reset mid-debounce: outs=%b", outs());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
